// File: rtl/aes_drv_pkg.sv
// Shared types, register word map and slot decode for the AES-192 register driver.
package aes_drv_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PT,
        ST_WR_KEY,
        ST_WR_SEL,
        ST_WR_GO,
        ST_WR_STOP,
        ST_POLL,
        ST_RD_CT,
        ST_RESP
    } state_t;

    localparam logic [5:0] IDX_START   = 6'd0;
    localparam logic [5:0] IDX_PT0     = 6'd1;
    localparam logic [5:0] IDX_KEY_S0  = 6'd5;
    localparam logic [5:0] IDX_KEY_S1  = 6'd20;
    localparam logic [5:0] IDX_KEY_S2  = 6'd26;
    localparam logic [5:0] IDX_KEY_SEL = 6'd32;
    localparam logic [5:0] IDX_STATUS  = 6'd11;
    localparam logic [5:0] IDX_CT0     = 6'd12;

    function automatic logic [5:0] key_base(input logic [1:0] slot);
        case (slot)
            2'd0:    return IDX_KEY_S0;
            2'd1:    return IDX_KEY_S1;
            default: return IDX_KEY_S2;
        endcase
    endfunction

endpackage

// File: rtl/aes_drv_bus_xfer.sv
// Single REG_BUS transfer engine: registers one request on go, holds it until
// ready, then pulses done with the captured read data and error flag.
module aes_drv_bus_xfer
    import aes_drv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    go,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    err,
    output logic [ADDR_WIDTH-1:0]   bus_addr_o,
    output logic                    bus_write_o,
    output logic [DATA_WIDTH-1:0]   bus_wdata_o,
    output logic [DATA_WIDTH/8-1:0] bus_wstrb_o,
    output logic                    bus_valid_o,
    input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
    input  logic                    bus_ready_i,
    input  logic                    bus_error_i
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus_addr_o  <= '0;
            bus_write_o <= 1'b0;
            bus_wdata_o <= '0;
            bus_wstrb_o <= '0;
            bus_valid_o <= 1'b0;
            done        <= 1'b0;
            rdata       <= '0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus_valid_o) begin
                if (bus_ready_i) begin
                    bus_valid_o <= 1'b0;
                    done        <= 1'b1;
                    rdata       <= bus_rdata_i;
                    err         <= bus_error_i;
                end
            end else if (go) begin
                // valid was low this cycle, so back-to-back transfers always see a gap
                bus_valid_o <= 1'b1;
                bus_addr_o  <= addr;
                bus_write_o <= write;
                bus_wdata_o <= write ? wdata : '0;
                bus_wstrb_o <= write ? '1 : '0;
            end
        end
    end

endmodule

// File: rtl/aes_reg_driver.sv
// Runs one AES-192 job over REG_BUS: program pt/key/slot, pulse start, poll, read ct.
// Optional key cache enabled by AES_DRV_KEY_CACHE_EN (skips key writes on a repeat key/slot).
//
// state      | meaning
// IDLE       | waiting for a job request
// WR_PT      | writing plaintext words idx1..4
// WR_KEY     | writing six key words to the slot's bank
// WR_SEL     | writing the slot number to key_sel
// WR_GO      | writing start = 1
// WR_STOP    | writing start = 0
// POLL       | reading status until ct_valid or timeout
// RD_CT      | reading ciphertext words idx12..15
// RESP       | presenting result until consumed
module aes_reg_driver
    import aes_drv_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    POLL_MAX   = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [127:0]            req_pt_i,
    input  logic [191:0]            req_key_i,
    input  logic [1:0]              req_slot_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [127:0]            rsp_ct_o,
    output logic                    rsp_err_o,
    output logic [ADDR_WIDTH-1:0]   bus_addr_o,
    output logic                    bus_write_o,
    output logic [DATA_WIDTH-1:0]   bus_wdata_o,
    output logic [DATA_WIDTH/8-1:0] bus_wstrb_o,
    output logic                    bus_valid_o,
    input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
    input  logic                    bus_ready_i,
    input  logic                    bus_error_i
);

    localparam int PW = $clog2(POLL_MAX + 1);

    state_t                  state;
    logic [2:0]              wcnt;
    logic [PW-1:0]           poll_cnt;
    logic [127:0]            pt_q;
    logic [191:0]            key_q;
    logic [1:0]              slot_q;
    logic [127:0]            ct_q;
    logic                    err_q;
    logic                    inflight;
    logic                    go, done, xfer_err, write;
    logic [DATA_WIDTH-1:0]   rdata, wdata;
    logic [5:0]              idx;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    key_hit, abort, key_done;

    always_comb begin
        idx   = IDX_START;
        write = 1'b1;
        wdata = '0;
        case (state)
            ST_WR_PT: begin
                idx   = IDX_PT0 + {3'b000, wcnt};
                wdata = pt_q[{wcnt, 5'd0} +: 32];
            end
            ST_WR_KEY: begin
                idx   = key_base(slot_q) + {3'b000, wcnt};
                wdata = key_q[{wcnt, 5'd0} +: 32];
            end
            ST_WR_SEL: begin
                idx   = IDX_KEY_SEL;
                wdata = DATA_WIDTH'(slot_q);
            end
            ST_WR_GO:   wdata = DATA_WIDTH'(1);
            ST_WR_STOP: wdata = '0;
            ST_POLL: begin
                idx   = IDX_STATUS;
                write = 1'b0;
            end
            ST_RD_CT: begin
                idx   = IDX_CT0 + {3'b000, wcnt};
                write = 1'b0;
            end
            default: ;
        endcase
    end

    assign addr     = BASE_ADDR + ADDR_WIDTH'({idx, 2'b00});
    assign go       = !inflight && (state != ST_IDLE) && (state != ST_RESP);
    assign abort    = done && (xfer_err ||
                      (state == ST_POLL && !rdata[0] && poll_cnt == PW'(POLL_MAX - 1)));
    assign key_done = done && !xfer_err && state == ST_WR_KEY && wcnt == 3'd5;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            wcnt     <= '0;
            poll_cnt <= '0;
            pt_q     <= '0;
            key_q    <= '0;
            slot_q   <= '0;
            ct_q     <= '0;
            err_q    <= 1'b0;
            inflight <= 1'b0;
        end else begin
            if (go)        inflight <= 1'b1;
            else if (done) inflight <= 1'b0;
            case (state)
                ST_IDLE: if (req_valid_i) begin
                    pt_q     <= req_pt_i;
                    key_q    <= req_key_i;
                    slot_q   <= (req_slot_i == 2'd3) ? 2'd2 : req_slot_i;
                    wcnt     <= '0;
                    poll_cnt <= '0;
                    state    <= ST_WR_PT;
                end
                ST_RESP: if (rsp_ready_i) state <= ST_IDLE;
                default: if (done) begin
                    if (abort) begin
                        state <= ST_RESP;
                        err_q <= 1'b1;
                        ct_q  <= '0;
                    end else begin
                        wcnt <= wcnt + 3'd1;
                        case (state)
                            ST_WR_PT: if (wcnt == 3'd3) begin
                                wcnt  <= '0;
                                state <= key_hit ? ST_WR_SEL : ST_WR_KEY;
                            end
                            ST_WR_KEY: if (wcnt == 3'd5) begin
                                wcnt  <= '0;
                                state <= ST_WR_SEL;
                            end
                            ST_WR_SEL:  state <= ST_WR_GO;
                            ST_WR_GO:   state <= ST_WR_STOP;
                            ST_WR_STOP: state <= ST_POLL;
                            ST_POLL: begin
                                wcnt <= '0;
                                if (rdata[0]) state <= ST_RD_CT;
                                else          poll_cnt <= poll_cnt + 1'b1;
                            end
                            ST_RD_CT: begin
                                ct_q[{wcnt, 5'd0} +: 32] <= rdata;
                                if (wcnt == 3'd3) begin
                                    state <= ST_RESP;
                                    err_q <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef AES_DRV_KEY_CACHE_EN
    logic [191:0] cache_key;
    logic [1:0]   cache_slot;
    logic         cache_vld;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cache_key  <= '0;
            cache_slot <= '0;
            cache_vld  <= 1'b0;
        end else if (abort) begin
            cache_vld <= 1'b0;
        end else if (key_done) begin
            cache_key  <= key_q;
            cache_slot <= slot_q;
            cache_vld  <= 1'b1;
        end
    end

    assign key_hit = cache_vld && cache_key == key_q && cache_slot == slot_q;
`else
    assign key_hit = 1'b0;
`endif

    assign req_ready_o = (state == ST_IDLE);
    assign rsp_valid_o = (state == ST_RESP);
    assign rsp_ct_o    = ct_q;
    assign rsp_err_o   = err_q;

    aes_drv_bus_xfer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_xfer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .go          (go),
        .addr        (addr),
        .write       (write),
        .wdata       (wdata),
        .done        (done),
        .rdata       (rdata),
        .err         (xfer_err),
        .bus_addr_o  (bus_addr_o),
        .bus_write_o (bus_write_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_wstrb_o (bus_wstrb_o),
        .bus_valid_o (bus_valid_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ready_i (bus_ready_i),
        .bus_error_i (bus_error_i)
    );

endmodule

// File: tb/tb_aes_reg_driver.sv
// Directed bench for aes_reg_driver with a REG_BUS responder model (POLL_MAX = 8).
module tb_aes_reg_driver;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         req_valid_i = 1'b0;
    logic         req_ready_o;
    logic [127:0] req_pt_i = '0;
    logic [191:0] req_key_i = '0;
    logic [1:0]   req_slot_i = '0;
    logic         rsp_valid_o;
    logic         rsp_ready_i = 1'b0;
    logic [127:0] rsp_ct_o;
    logic         rsp_err_o;
    logic [31:0]  bus_addr_o;
    logic         bus_write_o;
    logic [31:0]  bus_wdata_o;
    logic [3:0]   bus_wstrb_o;
    logic         bus_valid_o;
    logic [31:0]  bus_rdata_i = '0;
    logic         bus_ready_i = 1'b0;
    logic         bus_error_i = 1'b0;

    aes_reg_driver #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0), .POLL_MAX(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_pt_i(req_pt_i), .req_key_i(req_key_i), .req_slot_i(req_slot_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_ct_o(rsp_ct_o), .rsp_err_o(rsp_err_o),
        .bus_addr_o(bus_addr_o), .bus_write_o(bus_write_o), .bus_wdata_o(bus_wdata_o),
        .bus_wstrb_o(bus_wstrb_o), .bus_valid_o(bus_valid_o), .bus_rdata_i(bus_rdata_i),
        .bus_ready_i(bus_ready_i), .bus_error_i(bus_error_i)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [191:0] FIPS_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] FIPS_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

    int tests = 0;
    int fails = 0;

    // responder configuration and logs
    bit           rand_waits = 0;
    bit           status_never = 0;
    int           poll_delay = 2;
    int           err_idx = -1;
    int           status_reads = 0;
    int           viol = 0;
    logic [31:0]  wr_addr[$], wr_data[$], rd_addr[$];
    logic [31:0]  exp_a[$], exp_d[$];

    int           wait_left = 0;
    bit           waiting = 0;
    logic [68:0]  snap;
    bit           was_ready;
    int           cidx;

    always @(negedge clk_i) begin
        was_ready = bus_ready_i;
        if (was_ready && bus_valid_o) viol++;
        if (!was_ready && waiting && bus_valid_o &&
            {bus_addr_o, bus_write_o, bus_wdata_o, bus_wstrb_o} !== snap) viol++;
        bus_ready_i = 1'b0;
        bus_error_i = 1'b0;
        bus_rdata_i = '0;
        if (bus_valid_o && !was_ready) begin
            if (!waiting) begin
                wait_left = rand_waits ? $urandom_range(0, 5) : 0;
                snap = {bus_addr_o, bus_write_o, bus_wdata_o, bus_wstrb_o};
                waiting = 1;
            end
            if (wait_left == 0) begin
                waiting = 0;
                bus_ready_i = 1'b1;
                cidx = int'(bus_addr_o >> 2);
                if (cidx == err_idx) bus_error_i = 1'b1;
                if (bus_write_o) begin
                    if (bus_wstrb_o !== 4'hF) viol++;
                    wr_addr.push_back(bus_addr_o);
                    wr_data.push_back(bus_wdata_o);
                end else begin
                    if (bus_wstrb_o !== 4'h0) viol++;
                    rd_addr.push_back(bus_addr_o);
                    if (cidx == 11) begin
                        bus_rdata_i = {31'b0, !status_never && status_reads >= poll_delay};
                        status_reads++;
                    end else if (cidx >= 12 && cidx <= 15) begin
                        bus_rdata_i = FIPS_CT[32*(cidx-12) +: 32];
                    end
                end
            end else begin
                wait_left--;
            end
        end else begin
            waiting = 0;
        end
    end

`ifdef AES_DRV_KEY_CACHE_EN
    bit cache_en = 1;
`else
    bit cache_en = 0;
`endif
    bit           m_vld = 0;
    logic [191:0] m_key;
    logic [1:0]   m_slot;
    bit           last_skip;
    logic [127:0] r_ct;
    logic         r_err;
    bit           r_got;

    function automatic logic [1:0] norm(input logic [1:0] s);
        return (s == 2'd3) ? 2'd2 : s;
    endfunction

    task automatic build_exp(input logic [127:0] pt, input logic [191:0] key,
                             input logic [1:0] slot, input bit skip);
        int base;
        exp_a.delete(); exp_d.delete();
        for (int i = 0; i < 4; i++) begin
            exp_a.push_back(32'(4 * (1 + i))); exp_d.push_back(pt[32*i +: 32]);
        end
        base = (norm(slot) == 2'd0) ? 5 : (norm(slot) == 2'd1) ? 20 : 26;
        if (!skip)
            for (int i = 0; i < 6; i++) begin
                exp_a.push_back(32'(4 * (base + i))); exp_d.push_back(key[32*i +: 32]);
            end
        exp_a.push_back(32'd128); exp_d.push_back({30'b0, norm(slot)});
        exp_a.push_back(32'd0);   exp_d.push_back(32'd1);
        exp_a.push_back(32'd0);   exp_d.push_back(32'd0);
    endtask

    function automatic int wr_diffs();
        int n = 0;
        if (wr_addr.size() != exp_a.size()) return 1000 + wr_addr.size();
        foreach (exp_a[i]) if (wr_addr[i] !== exp_a[i] || wr_data[i] !== exp_d[i]) n++;
        return n;
    endfunction

    function automatic int key_writes();
        int n = 0;
        foreach (wr_addr[i]) if (wr_addr[i] >= 32'd20 && wr_addr[i] <= 32'd40) n++;
        return n;
    endfunction

    task automatic run_job(input logic [127:0] pt, input logic [191:0] key, input logic [1:0] slot);
        last_skip = cache_en && m_vld && m_key == key && m_slot == norm(slot);
        wr_addr.delete(); wr_data.delete(); rd_addr.delete();
        status_reads = 0;
        @(negedge clk_i);
        req_pt_i = pt; req_key_i = key; req_slot_i = slot; req_valid_i = 1'b1;
        @(posedge clk_i); #1 req_valid_i = 1'b0;
        r_got = 0; r_ct = '0; r_err = 1'b0;
        for (int i = 0; i < 3000 && !r_got; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) begin r_got = 1; r_ct = rsp_ct_o; r_err = rsp_err_o; end
        end
        tests++;
        if (!r_got) begin fails++; $display("FAIL rsp_timeout: no rsp_valid_o within 3000 cycles"); end
        else begin rsp_ready_i = 1'b1; @(posedge clk_i); #1 rsp_ready_i = 1'b0; end
        repeat (6) @(negedge clk_i);
        if (r_err) m_vld = 0;
        else if (!last_skip) begin m_vld = 1; m_key = key; m_slot = norm(slot); end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        tests++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b want 1", req_ready_o); end
        tests++; if (rsp_valid_o !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
        tests++; if (bus_valid_o !== 1'b0 || bus_wstrb_o !== 4'h0 || bus_addr_o !== 32'h0)
            begin fails++; $display("FAIL reset_bus: valid %b wstrb %h addr %h want 0", bus_valid_o, bus_wstrb_o, bus_addr_o); end
        tests++; if (rsp_ct_o !== 128'h0 || rsp_err_o !== 1'b0)
            begin fails++; $display("FAIL reset_rsp: ct %h err %b want 0", rsp_ct_o, rsp_err_o); end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_fips();
        int n;
        rand_waits = 0; status_never = 0; poll_delay = 2; err_idx = -1;
        run_job(FIPS_PT, FIPS_KEY, 2'd0);
        build_exp(FIPS_PT, FIPS_KEY, 2'd0, last_skip);
        n = wr_diffs();
        tests++; if (n !== 0) begin fails++; $display("FAIL fips_writes: %0d diffs (writes %0d want %0d)", n, wr_addr.size(), exp_a.size()); end
        n = 0;
        if (rd_addr.size() != 7) n = 100;
        else for (int i = 0; i < 7; i++) if (rd_addr[i] !== ((i < 3) ? 32'd44 : 32'(48 + 4*(i-3)))) n++;
        tests++; if (n !== 0) begin fails++; $display("FAIL fips_reads: %0d diffs (reads %0d want 7)", n, rd_addr.size()); end
        tests++; if (r_ct !== FIPS_CT) begin fails++; $display("FAIL fips_ct: got %h want %h", r_ct, FIPS_CT); end
        tests++; if (r_err !== 1'b0) begin fails++; $display("FAIL fips_err: got %b want 0", r_err); end
        tests++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL fips_idle: req_ready %b want 1", req_ready_o); end
    endtask

    task automatic test_wait_states();
        int n;
        rand_waits = 1; viol = 0;
        for (int j = 0; j < 2; j++) begin
            run_job(FIPS_PT, FIPS_KEY, 2'd0);
            build_exp(FIPS_PT, FIPS_KEY, 2'd0, last_skip);
            n = wr_diffs();
            tests++; if (n !== 0) begin fails++; $display("FAIL wait_writes: %0d diffs", n); end
            tests++; if (r_ct !== FIPS_CT || r_err !== 1'b0)
                begin fails++; $display("FAIL wait_ct: got %h err %b want %h err 0", r_ct, r_err, FIPS_CT); end
        end
        tests++; if (viol !== 0) begin fails++; $display("FAIL wait_bus_stable: %0d protocol violations want 0", viol); end
        rand_waits = 0;
    endtask

    task automatic test_timeout();
        int n = 0;
        status_never = 1;
        run_job(FIPS_PT, FIPS_KEY, 2'd0);
        foreach (rd_addr[i]) if (rd_addr[i] !== 32'd44) n++;
        tests++; if (rd_addr.size() != 8 || n != 0)
            begin fails++; $display("FAIL timeout_polls: %0d reads (%0d non-status) want 8 status", rd_addr.size(), n); end
        tests++; if (r_err !== 1'b1 || r_ct !== 128'h0)
            begin fails++; $display("FAIL timeout_rsp: err %b ct %h want err 1 ct 0", r_err, r_ct); end
        status_never = 0;
    endtask

    task automatic test_bus_error();
        err_idx = 7;
        run_job(FIPS_PT, FIPS_KEY, 2'd0);
        tests++; if (wr_addr.size() != 7 || rd_addr.size() != 0 || wr_addr[wr_addr.size()-1] !== 32'd28)
            begin fails++; $display("FAIL buserr_stop: %0d writes %0d reads want 7 writes ending at 28, 0 reads", wr_addr.size(), rd_addr.size()); end
        tests++; if (r_err !== 1'b1 || r_ct !== 128'h0)
            begin fails++; $display("FAIL buserr_rsp: err %b ct %h want err 1 ct 0", r_err, r_ct); end
        err_idx = -1;
    endtask

    task automatic test_slot2();
        int n;
        logic [1:0] slots [2] = '{2'd2, 2'd3};
        for (int j = 0; j < 2; j++) begin
            run_job(FIPS_PT, FIPS_KEY, slots[j]);
            build_exp(FIPS_PT, FIPS_KEY, slots[j], last_skip);
            n = wr_diffs();
            tests++; if (n !== 0) begin fails++; $display("FAIL slot%0d_writes: %0d diffs", slots[j], n); end
            tests++; if (r_ct !== FIPS_CT || r_err !== 1'b0)
                begin fails++; $display("FAIL slot%0d_ct: got %h err %b", slots[j], r_ct, r_err); end
        end
    endtask

    task automatic test_key_cache();
        logic [191:0] key2;
        int n;
        key2 = FIPS_KEY ^ 192'h1;
        run_job(FIPS_PT, key2, 2'd0);
        n = key_writes();
        tests++; if (n !== 6) begin fails++; $display("FAIL cache_first: %0d key writes want 6", n); end
        run_job(FIPS_PT, key2, 2'd0);
        n = key_writes();
        tests++; if (n !== (cache_en ? 0 : 6)) begin fails++; $display("FAIL cache_repeat: %0d key writes want %0d", n, cache_en ? 0 : 6); end
        build_exp(FIPS_PT, key2, 2'd0, cache_en);
        n = wr_diffs();
        tests++; if (n !== 0) begin fails++; $display("FAIL cache_repeat_seq: %0d diffs", n); end
        run_job(FIPS_PT, FIPS_KEY, 2'd0);
        n = key_writes();
        tests++; if (n !== 6) begin fails++; $display("FAIL cache_changed: %0d key writes want 6", n); end
    endtask

    task automatic test_reset_mid_job();
        bit seen = 0;
        @(negedge clk_i);
        req_pt_i = FIPS_PT; req_key_i = FIPS_KEY; req_slot_i = 2'd0; req_valid_i = 1'b1;
        @(posedge clk_i); #1 req_valid_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        tests++; if (req_ready_o !== 1'b1 || bus_valid_o !== 1'b0 || rsp_valid_o !== 1'b0)
            begin fails++; $display("FAIL midrst_state: ready %b bus_valid %b rsp_valid %b want 1 0 0", req_ready_o, bus_valid_o, rsp_valid_o); end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        m_vld = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk_i); if (rsp_valid_o || bus_valid_o) seen = 1; end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midrst_abandon: activity after reset, want none"); end
        run_job(FIPS_PT, FIPS_KEY, 2'd1);
        build_exp(FIPS_PT, FIPS_KEY, 2'd1, last_skip);
        tests++; if (wr_diffs() !== 0 || r_ct !== FIPS_CT)
            begin fails++; $display("FAIL midrst_next_job: diffs %0d ct %h", wr_diffs(), r_ct); end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_wait_states();
        test_timeout();
        test_bus_error();
        test_slot2();
        test_key_cache();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
